// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and default sizing constants for mult_share_arbiter.
//   state_t      : IDLE / CALC / CALC2 / DONE (CALC2 only reached with MULT_SHARE_PIPE_EN)
//   DEF_NUM_REQ  : default requester count
//   DEF_WIDTH    : default operand width
package mult_pkg;
    typedef enum logic [1:0] {IDLE, CALC, CALC2, DONE} state_t;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH = 4;
endpackage

// File: rtl/mult_core.sv
// mult_core: combinational WIDTH x WIDTH unsigned array multiplier.
//   a, b : unsigned operands
//   p    : full 2*WIDTH-bit product
module mult_core
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);
    always_comb begin
        p = '0;
        for (int i = 0; i < WIDTH; i++)
            p = b[i] ? p + ((2*WIDTH)'(a) << i) : p;
    end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin arbiter sharing one multiplier among NUM_REQ requesters.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake, req_ready one-hot in IDLE only
//   req_a, req_b         : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready  : result handshake, rsp_valid high in DONE only
//   rsp_id, rsp_product  : owner index and unsigned product, stable while in DONE
// Optional: define MULT_SHARE_PIPE_EN to add a pipeline register (state CALC2), latency 3 instead of 2.
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [2*WIDTH-1:0]         rsp_product
);
    localparam int IW = $clog2(NUM_REQ);

    state_t state, state_nx;
    logic [IW-1:0] rr_ptr, gnt, idx;
    logic [WIDTH-1:0] op_a, op_b;
    logic [2*WIDTH-1:0] prod;
    logic any_req, take;
`ifdef MULT_SHARE_PIPE_EN
    logic [2*WIDTH-1:0] prod_q;
`endif

    assign any_req = |req_valid;
    assign take = (state == IDLE) && any_req;
    assign rsp_valid = (state == DONE);

    // Scan downward so the lowest offset from rr_ptr with valid set wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
            gnt = req_valid[idx] ? idx : gnt;
        end
    end

    // Gated by rst_n so ready is low for the whole reset, not just from the next edge.
    always_comb begin
        req_ready = '0;
        if (rst_n && take)
            req_ready[gnt] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = any_req ? CALC : IDLE;
`ifdef MULT_SHARE_PIPE_EN
            CALC:  state_nx = CALC2;
            CALC2: state_nx = DONE;
`else
            CALC:  state_nx = DONE;
`endif
            DONE:  state_nx = rsp_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rr_ptr <= '0;
            op_a <= '0;
            op_b <= '0;
            rsp_id <= '0;
            rsp_product <= '0;
`ifdef MULT_SHARE_PIPE_EN
            prod_q <= '0;
`endif
        end else begin
            if (take) begin
                op_a <= req_a[int'(gnt)*WIDTH +: WIDTH];
                op_b <= req_b[int'(gnt)*WIDTH +: WIDTH];
                rsp_id <= gnt;
                rr_ptr <= IW'((int'(gnt) + 1) % NUM_REQ);
            end
`ifdef MULT_SHARE_PIPE_EN
            if (state == CALC)
                prod_q <= prod;
            if (state == CALC2)
                rsp_product <= prod_q;
`else
            if (state == CALC)
                rsp_product <= prod;
`endif
        end

    mult_core #(.WIDTH(WIDTH)) u_mult (
        .a(op_a),
        .b(op_b),
        .p(prod)
    );
endmodule
